mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux: walks sel 0..3, samples mux_out per channel and
// presents the assembled word with a valid/ready handshake. Optional MUX_SCAN_PARITY_EN adds data_parity.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE     = 1,
    parameter int unsigned CONTINUOUS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_out,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] data,
    output logic       data_valid
`ifdef MUX_SCAN_PARITY_EN
   ,output logic       data_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] LP_CNT_LAST = 3'(SETTLE - 1);

    state_t     r_state;
    logic [1:0] r_sel;
    logic       r_busy;
    logic [3:0] r_data;
    logic       r_valid;
    logic [1:0] r_idx;
    logic [2:0] r_cnt;
    logic [3:0] r_shadow;
    logic [3:0] w_shadow_nxt;
    logic       w_handshake;
    logic       w_restart;

    // Shadow word with the current channel's sample merged in; used at every capture edge.
    always_comb begin
        w_shadow_nxt        = r_shadow;
        w_shadow_nxt[r_idx] = mux_out;
    end

    assign w_handshake = r_valid & out_ready;
    assign w_restart   = (CONTINUOUS != 0) | start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SCAN;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_sel   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (r_cnt == LP_CNT_LAST) begin
                        r_shadow <= w_shadow_nxt;
                        if (r_idx == 2'd3) begin
                            r_state <= HOLD;
                            r_data  <= w_shadow_nxt;
                            r_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                            r_sel <= r_idx + 2'd1;
                            r_cnt <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_sel   <= '0;
                        if (w_restart) begin
                            r_state <= SCAN;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sel   <= '0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_parity;

    // Loaded on the same edge as data, from the same merged shadow word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (r_state == SCAN && r_cnt == LP_CNT_LAST && r_idx == 2'd3) begin
            r_parity <= ^w_shadow_nxt;
        end
    end

    assign data_parity = r_parity;
`endif

    assign sel        = r_sel;
    assign busy       = r_busy;
    assign data       = r_data;
    assign data_valid = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl: SETTLE=1, SETTLE=3 and CONTINUOUS=1 instances
// each driven by a behavioural 4:1 mux over a bench-held pattern.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start1 = 1'b0, ready1 = 1'b0, mux1;
    logic [3:0] pat1 = '0;
    logic [1:0] sel1;
    logic       busy1, valid1;
    logic [3:0] data1;

    logic       start3 = 1'b0, ready3 = 1'b0, mux3;
    logic [3:0] pat3 = '0;
    logic [1:0] sel3;
    logic       busy3, valid3;
    logic [3:0] data3;

    logic       startc = 1'b0, readyc = 1'b0, muxc;
    logic [3:0] patc = '0;
    logic [1:0] selc;
    logic       busyc, validc;
    logic [3:0] datac;

`ifdef MUX_SCAN_PARITY_EN
    logic par1, par3, parc;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mux1 = pat1[sel1];
    assign mux3 = pat3[sel3];
    assign muxc = patc[selc];

    mux_scan_ctrl #(.SETTLE(1), .CONTINUOUS(0)) u_s1 (
        .clk(clk), .rst(rst), .start(start1), .mux_out(mux1), .out_ready(ready1),
        .sel(sel1), .busy(busy1), .data(data1), .data_valid(valid1)
`ifdef MUX_SCAN_PARITY_EN
       ,.data_parity(par1)
`endif
    );

    mux_scan_ctrl #(.SETTLE(3), .CONTINUOUS(0)) u_s3 (
        .clk(clk), .rst(rst), .start(start3), .mux_out(mux3), .out_ready(ready3),
        .sel(sel3), .busy(busy3), .data(data3), .data_valid(valid3)
`ifdef MUX_SCAN_PARITY_EN
       ,.data_parity(par3)
`endif
    );

    mux_scan_ctrl #(.SETTLE(1), .CONTINUOUS(1)) u_cont (
        .clk(clk), .rst(rst), .start(startc), .mux_out(muxc), .out_ready(readyc),
        .sel(selc), .busy(busyc), .data(datac), .data_valid(validc)
`ifdef MUX_SCAN_PARITY_EN
       ,.data_parity(parc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with start asserted
        rst = 1'b1; start1 = 1'b1; start3 = 1'b1; startc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_sel",   32'(sel1),   32'd0);
            chk("rst_busy",  32'(busy1),  32'd0);
            chk("rst_data",  32'(data1),  32'd0);
            chk("rst_valid", 32'(valid1), 32'd0);
            chk("rst_busy3", 32'(busy3),  32'd0);
            chk("rst_busyc", 32'(busyc),  32'd0);
        end
        start3 = 1'b0; startc = 1'b0;

        // SETTLE=1 scan, start honoured on first edge out of reset
        pat1 = 4'b1010;
        rst  = 1'b0;
        tick();
        chk("s1_busy_e0", 32'(busy1), 32'd1);
        chk("s1_sel_e0",  32'(sel1),  32'd0);
        start1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("s1_sel_seq",   32'(sel1),   32'(k));
            chk("s1_valid_low", 32'(valid1), 32'd0);
        end
        tick();
        chk("s1_valid", 32'(valid1), 32'd1);
        chk("s1_data",  32'(data1),  32'b1010);
        chk("s1_hold_sel", 32'(sel1), 32'd3);
`ifdef MUX_SCAN_PARITY_EN
        chk("s1_par_1010", 32'(par1), 32'd0);
`endif
        // Handshake with start high restarts immediately
        ready1 = 1'b1; start1 = 1'b1; pat1 = 4'b0111;
        tick();
        chk("s1_hs_valid", 32'(valid1), 32'd0);
        chk("s1_hs_busy",  32'(busy1),  32'd1);
        chk("s1_hs_sel",   32'(sel1),   32'd0);
        chk("s1_hs_data",  32'(data1),  32'b1010);
        ready1 = 1'b0; start1 = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        tick();
        chk("s1_data2", 32'(data1), 32'b0111);
        chk("s1_valid2", 32'(valid1), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
        chk("s1_par_0111", 32'(par1), 32'd1);
`endif
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("s1_idle_busy", 32'(busy1), 32'd0);
        chk("s1_idle_sel",  32'(sel1),  32'd0);
        chk("s1_keep_data", 32'(data1), 32'b0111);

        // SETTLE=3 scan with backpressure and ignored start pulses
        pat3 = 4'b0110; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            if (n == 4) start3 = 1'b1;
            if (n == 5) start3 = 1'b0;
            tick();
            chk("s3_sel_seq",   32'(sel3),   32'(n / 3));
            chk("s3_valid_low", 32'(valid3), 32'd0);
        end
        tick();
        chk("s3_valid_12", 32'(valid3), 32'd1);
        chk("s3_data",     32'(data3),  32'b0110);
        for (int n = 0; n < 5; n++) begin
            start3 = (n == 1 || n == 3);
            pat3   = 4'b1001;
            tick();
            chk("s3_stall_valid", 32'(valid3), 32'd1);
            chk("s3_stall_data",  32'(data3),  32'b0110);
            chk("s3_stall_sel",   32'(sel3),   32'd3);
            chk("s3_stall_busy",  32'(busy3),  32'd1);
        end
        start3 = 1'b0; ready3 = 1'b1;
        tick();
        ready3 = 1'b0;
        chk("s3_hs_valid", 32'(valid3), 32'd0);
        chk("s3_hs_busy",  32'(busy3),  32'd0);
        tick();
        chk("s3_idle_stay", 32'(busy3), 32'd0);
        chk("s3_keep_data", 32'(data3), 32'b0110);

        // CONTINUOUS=1 back-to-back results
        patc = 4'b0001; startc = 1'b1; readyc = 1'b1;
        tick();
        startc = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("c_busy_a", 32'(busyc), 32'd1);
        end
        tick();
        chk("c_valid_a", 32'(validc), 32'd1);
        chk("c_data_a",  32'(datac),  32'b0001);
        patc = 4'b1000;
        tick();
        chk("c_hs_busy",  32'(busyc),  32'd1);
        chk("c_hs_valid", 32'(validc), 32'd0);
        chk("c_hs_sel",   32'(selc),   32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("c_busy_b", 32'(busyc), 32'd1);
        end
        tick();
        chk("c_valid_b", 32'(validc), 32'd1);
        chk("c_data_b",  32'(datac),  32'b1000);
        readyc = 1'b0;

        // Reset after two channels captured discards the partial scan
        pat1 = 4'b1100; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        chk("mr_sel_pre", 32'(sel1), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy",  32'(busy1),  32'd0);
        chk("mr_sel",   32'(sel1),   32'd0);
        chk("mr_data",  32'(data1),  32'd0);
        chk("mr_valid", 32'(valid1), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr_no_valid", 32'(valid1), 32'd0);
            chk("mr_idle",     32'(busy1),  32'd0);
        end
        pat1 = 4'b0011; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("mr_valid_low", 32'(valid1), 32'd0);
        end
        tick();
        chk("mr_valid2", 32'(valid1), 32'd1);
        chk("mr_data2",  32'(data1),  32'b0011);
`ifdef MUX_SCAN_PARITY_EN
        chk("mr_par_0011", 32'(par1), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
